// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract: one full-add cell used WIDTH times, LSB first.
// Latency: result valid WIDTH+1 cycles after the cycle operands are presented.
// Backpressure: result held in DONE until out_ready; in_ready low while RUN.

module full_add_cell #(
  parameter string MODEL = "Behavioral"
) (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic c,
  output logic co
);
  generate
    if (MODEL == "DataFlow") begin : g_dataflow
      assign c  = a ^ b ^ ci;
      assign co = (a & b) | (ci & (a ^ b));
    end else if (MODEL == "Structural") begin : g_structural
      logic axb, ab, cxab;
      xor u_x0 (axb, a, b);
      xor u_x1 (c, axb, ci);
      and u_a0 (ab, a, b);
      and u_a1 (cxab, axb, ci);
      or  u_o0 (co, ab, cxab);
    end else begin : g_behavioral
      always_comb begin
        {co, c} = {1'b0, a} + {1'b0, b} + {1'b0, ci};
      end
    end
  endgenerate
endmodule

module serial_add_sequencer #(
  parameter int    WIDTH = 16,
  parameter string MODEL = "Behavioral"
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] MSB_CIN_BIT = CW'(WIDTH - 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] op_a, op_b, res;
  logic             carry, msb_cin;
  logic             cell_c, cell_co;
  logic             accept;

  full_add_cell #(.MODEL(MODEL)) u_cell (
    .a  (op_a[0]),
    .b  (op_b[0]),
    .ci (carry),
    .c  (cell_c),
    .co (cell_co)
  );

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign accept    = in_valid & in_ready;
  assign sum       = res;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (cnt == LAST_BIT) state_d = DONE;
      DONE: if (out_ready) state_d = in_valid ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Result bits enter at the MSB and shift down, so bit i settles at index i.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      carry   <= 1'b0;
      msb_cin <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      res     <= '0;
      co      <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= sub ? ~b : b;
      carry <= sub | ci;
      cnt   <= '0;
    end else if (state_q == RUN) begin
      res   <= {cell_c, res[WIDTH-1:1]};
      carry <= cell_co;
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      if (cnt == MSB_CIN_BIT) msb_cin <= cell_co;
      if (cnt == LAST_BIT) begin
        co  <= cell_co;
        ovf <= msb_cin ^ cell_co;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule
